// File: rtl/pe_array_pkg.sv
// rtl/pe_array_pkg.sv - shared FSM type, FP16 constants and FP16 arithmetic for the PE array
//
// Contents:
//   state_t      : job FSM states (IDLE, FEED, FLUSH, DRAIN)
//   FP16_W       : FP16 word width
//   FP16_ZERO    : +0.0
//   FP16_ONE     : +1.0 (its exponent field doubles as the exponent bias)
//   fp16_mul     : FP16 multiply, round-to-nearest-even
//   fp16_add     : FP16 add, round-to-nearest-even
// Subnormal operands are treated as zero and underflowing results flush to zero.
// Infinity/NaN operands produce a signed infinity.
package pe_array_pkg;

    localparam int          FP16_W    = 16;
    localparam logic [15:0] FP16_ZERO = 16'h0000;
    localparam logic [15:0] FP16_ONE  = 16'h3C00;
    localparam logic [15:0] FP16_INF  = 16'h7C00;
    localparam int          FP16_BIAS = int'(FP16_ONE[14:10]);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FEED,
        ST_FLUSH,
        ST_DRAIN
    } state_t;

    function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
        logic        s;
        logic [21:0] p;
        logic [11:0] r;
        logic        rnd;
        int          e;
        s = a[15] ^ b[15];
        if (a[14:10] == 5'd0 || b[14:10] == 5'd0) return {s, 15'd0};
        if (a[14:10] == 5'h1f || b[14:10] == 5'h1f) return {s, FP16_INF[14:0]};
        p = {11'd0, 1'b1, a[9:0]} * {11'd0, 1'b1, b[9:0]};
        e = int'(a[14:10]) + int'(b[14:10]) - FP16_BIAS;
        // Product of two 1.x mantissas is in [1,4); bit 21 set means [2,4).
        if (p[21]) begin
            e   = e + 1;
            rnd = p[10] & (p[11] | (|p[9:0]));
            r   = {1'b0, p[21:11]} + 12'(rnd);
        end else begin
            rnd = p[9] & (p[10] | (|p[8:0]));
            r   = {1'b0, p[20:10]} + 12'(rnd);
        end
        if (r[11]) begin
            r = r >> 1;
            e = e + 1;
        end
        if (e <= 0) return {s, 15'd0};
        if (e >= 31) return {s, FP16_INF[14:0]};
        return {s, e[4:0], r[9:0]};
    endfunction

    function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x;
        logic [15:0] y;
        logic [13:0] mx;
        logic [13:0] my;
        logic [14:0] s;
        logic [11:0] r;
        int          d;
        int          e;
        // x is the operand of larger magnitude; its sign is the result sign.
        if (a[14:0] < b[14:0]) begin
            x = b;
            y = a;
        end else begin
            x = a;
            y = b;
        end
        if (y[14:10] == 5'd0) return x;
        if (x[14:10] == 5'h1f) return x;
        // Three guard bits below the mantissa; bit 0 is kept sticky while aligning.
        mx = {1'b1, x[9:0], 3'b000};
        my = {1'b1, y[9:0], 3'b000};
        d  = int'(x[14:10]) - int'(y[14:10]);
        for (int i = 0; i < 14; i++) begin
            if (i < d) my = {1'b0, my[13:2], my[1] | my[0]};
        end
        e = int'(x[14:10]);
        if (x[15] == y[15]) s = {1'b0, mx} + {1'b0, my};
        else                s = {1'b0, mx} - {1'b0, my};
        if (s == 15'd0) return 16'h0000;
        if (s[14]) begin
            s = {1'b0, s[14:2], s[1] | s[0]};
            e = e + 1;
        end else begin
            for (int i = 0; i < 13; i++) begin
                if (!s[13]) begin
                    s = s << 1;
                    e = e - 1;
                end
            end
        end
        r = {1'b0, s[13:3]} + 12'(s[2] & (s[1] | s[0] | s[3]));
        if (r[11]) begin
            r = r >> 1;
            e = e + 1;
        end
        if (e <= 0) return {x[15], 15'd0};
        if (e >= 31) return {x[15], FP16_INF[14:0]};
        return {x[15], e[4:0], r[9:0]};
    endfunction

endpackage

// File: rtl/pe_mac.sv
// rtl/pe_mac.sv - one systolic processing element: FP16 multiply-accumulate with operand pass-through
//
// Ports:
//   clk, reset : clock, asynchronous active-low reset
//   en         : advance one step (register operands onward, accumulate a_in*b_in)
//   clr        : clear the accumulator (has priority over en)
//   a_in, b_in : operands from the left / top neighbour
//   a_out,b_out: operands registered for the right / bottom neighbour
//   acc        : running FP16 dot-product
module pe_mac
    import pe_array_pkg::*;
#(
    parameter int DATA_WIDTH = FP16_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic [DATA_WIDTH-1:0] b_out,
    output logic [DATA_WIDTH-1:0] acc
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_out <= FP16_ZERO;
            b_out <= FP16_ZERO;
            acc   <= FP16_ZERO;
        end else if (clr) begin
            acc <= FP16_ZERO;
        end else if (en) begin
            a_out <= a_in;
            b_out <= b_in;
            acc   <= fp16_add(acc, fp16_mul(a_in, b_in));
        end
    end

endmodule

// File: rtl/pe_array_nxn.sv
// rtl/pe_array_nxn.sv - ROWSxCOLS output-stationary FP16 systolic matrix multiplier
//
// Computes C = A(ROWS x k_len) * B(k_len x COLS). Each operand beat carries one column
// of A and one row of B unskewed; the array skews them internally. Results leave one
// row per beat on out_data after the pipeline has flushed.
//
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   start, k_len        : begin a job of k_len beats (1..KMAX), sampled in IDLE only
//   acc_keep            : keep accumulators across start (only with PE_ARRAY_ACC_KEEP_EN)
//   in_valid, in_ready  : operand beat handshake
//   a_data, b_data      : A column k (row i at slice i), B row k (column j at slice j)
//   out_valid,out_ready : result row handshake
//   out_row, out_data   : row index and C[out_row][0..COLS-1]
//   busy, done          : job active, one-cycle completion pulse
//
// Build option: define PE_ARRAY_ACC_KEEP_EN to add the acc_keep input.
module pe_array_nxn
    import pe_array_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = FP16_W,
    parameter int KMAX       = 16
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [$clog2(KMAX+1)-1:0]              k_len,
`ifdef PE_ARRAY_ACC_KEEP_EN
    input  logic                                   acc_keep,
`endif
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0]             a_data,
    input  logic [COLS*DATA_WIDTH-1:0]             b_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [(ROWS > 1 ? $clog2(ROWS) : 1)-1:0] out_row,
    output logic [COLS*DATA_WIDTH-1:0]             out_data,
    output logic                                   busy,
    output logic                                   done
);

    localparam int KW        = $clog2(KMAX + 1);
    localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int FLUSH_LEN = ROWS + COLS - 2;
    localparam int FW        = $clog2(ROWS + COLS);

    state_t          state;
    state_t          state_nxt;
    logic [KW-1:0]   k_target;
    logic [KW-1:0]   k_cnt;
    logic [FW-1:0]   f_cnt;
    logic            start_ok;
    logic            job_start;
    logic            keep;
    logic            clr_acc;
    logic            step;
    logic            last_beat;
    logic            last_row;

    logic [DATA_WIDTH-1:0] a_h   [ROWS][COLS];
    logic [DATA_WIDTH-1:0] b_v   [ROWS][COLS];
    logic [DATA_WIDTH-1:0] acc_m [ROWS][COLS];
    logic [DATA_WIDTH-1:0] unused_a_end [ROWS];
    logic [DATA_WIDTH-1:0] unused_b_end [COLS];

`ifdef PE_ARRAY_ACC_KEEP_EN
    assign keep = acc_keep;
`else
    assign keep = 1'b0;
`endif

    assign start_ok  = start && (k_len != '0) && (k_len <= KW'(KMAX));
    assign job_start = (state == ST_IDLE) && start_ok;
    assign clr_acc   = job_start && !keep;
    assign last_beat = (k_cnt == k_target - KW'(1));
    assign last_row  = (out_row == RW'(ROWS - 1));
    // The whole array moves in lock-step: on accepted beats while feeding, and on
    // every FLUSH cycle (zeros injected) so the last products reach the far corner.
    assign step      = ((state == ST_FEED) && in_valid) || (state == ST_FLUSH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start_ok) state_nxt = ST_FEED;
            end
            ST_FEED: begin
                in_ready = 1'b1;
                if (in_valid && last_beat) state_nxt = (FLUSH_LEN == 0) ? ST_DRAIN : ST_FLUSH;
            end
            ST_FLUSH: begin
                if (f_cnt == FW'(FLUSH_LEN - 1)) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && last_row) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k_target <= '0;
            k_cnt    <= '0;
            f_cnt    <= '0;
            out_row  <= '0;
            done     <= 1'b0;
        end else begin
            done <= (state == ST_DRAIN) && out_ready && last_row;
            if (job_start) begin
                k_target <= k_len;
                k_cnt    <= '0;
                f_cnt    <= '0;
            end
            if ((state == ST_FEED) && in_valid) k_cnt <= k_cnt + KW'(1);
            if (state == ST_FLUSH) f_cnt <= f_cnt + FW'(1);
            if ((state == ST_DRAIN) && out_ready) out_row <= last_row ? '0 : out_row + RW'(1);
        end
    end

    // Row i of A enters i steps late so it meets column j of B (j steps late) at PE(i,j).
    for (genvar i = 0; i < ROWS; i++) begin : g_a_skew
        logic [DATA_WIDTH-1:0] a_new;
        assign a_new = (state == ST_FEED) ? a_data[i*DATA_WIDTH +: DATA_WIDTH] : FP16_ZERO;
        if (i == 0) begin : g_direct
            assign a_h[0][0] = a_new;
        end else begin : g_delay
            logic [DATA_WIDTH-1:0] dly [i];
            always_ff @(posedge clk or negedge reset) begin
                if (!reset || job_start) begin
                    for (int n = 0; n < i; n++) dly[n] <= FP16_ZERO;
                end else if (step) begin
                    dly[0] <= a_new;
                    for (int n = 1; n < i; n++) dly[n] <= dly[n-1];
                end
            end
            assign a_h[i][0] = dly[i-1];
        end
    end

    for (genvar j = 0; j < COLS; j++) begin : g_b_skew
        logic [DATA_WIDTH-1:0] b_new;
        assign b_new = (state == ST_FEED) ? b_data[j*DATA_WIDTH +: DATA_WIDTH] : FP16_ZERO;
        if (j == 0) begin : g_direct
            assign b_v[0][0] = b_new;
        end else begin : g_delay
            logic [DATA_WIDTH-1:0] dly [j];
            always_ff @(posedge clk or negedge reset) begin
                if (!reset || job_start) begin
                    for (int n = 0; n < j; n++) dly[n] <= FP16_ZERO;
                end else if (step) begin
                    dly[0] <= b_new;
                    for (int n = 1; n < j; n++) dly[n] <= dly[n-1];
                end
            end
            assign b_v[0][j] = dly[j-1];
        end
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_col
            logic [DATA_WIDTH-1:0] a_o;
            logic [DATA_WIDTH-1:0] b_o;
            pe_mac #(.DATA_WIDTH(DATA_WIDTH)) u_pe (
                .clk   (clk),
                .reset (reset),
                .en    (step),
                .clr   (clr_acc),
                .a_in  (a_h[i][j]),
                .b_in  (b_v[i][j]),
                .a_out (a_o),
                .b_out (b_o),
                .acc   (acc_m[i][j])
            );
            if (j < COLS - 1) begin : g_a_link
                assign a_h[i][j+1] = a_o;
            end else begin : g_a_end
                assign unused_a_end[i] = a_o;
            end
            if (i < ROWS - 1) begin : g_b_link
                assign b_v[i+1][j] = b_o;
            end else begin : g_b_end
                assign unused_b_end[j] = b_o;
            end
        end
    end

    // Accumulators are frozen in DRAIN, so the selected row is stable under stall.
    always_comb begin
        out_data = '0;
        if (state == ST_DRAIN) begin
            for (int j = 0; j < COLS; j++) out_data[j*DATA_WIDTH +: DATA_WIDTH] = acc_m[out_row][j];
        end
    end

endmodule

// File: tb/tb_pe_array_nxn.sv
// tb/tb_pe_array_nxn.sv - self-checking bench for pe_array_nxn (4x4, FP16, KMAX=16)
module tb_pe_array_nxn;

    typedef struct packed {
        int                     k;
        bit                     gap;
        bit                     stall;
        bit                     poke;
        bit                     keep;
        logic [3:0][15:0][15:0] a;
        logic [15:0][3:0][15:0] b;
        logic [3:0][3:0][15:0]  c;
    } vec_t;

`ifdef PE_ARRAY_ACC_KEEP_EN
    localparam int NV = 7;
`else
    localparam int NV = 6;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  k_len = '0;
    logic        acc_keep = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] a_data = '0;
    logic [63:0] b_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [1:0]  out_row;
    logic [63:0] out_data;
    logic        busy;
    logic        done;

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs [NV];
    logic [15:0] bvals [4][4];

    always #5 clk = ~clk;

    pe_array_nxn #(.ROWS(4), .COLS(4), .DATA_WIDTH(16), .KMAX(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .k_len     (k_len),
`ifdef PE_ARRAY_ACC_KEEP_EN
        .acc_keep  (acc_keep),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_data    (a_data),
        .b_data    (b_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_const(input int idx, input int k, input logic [15:0] av,
                              input logic [15:0] bv, input logic [15:0] cv);
        vecs[idx]   = '0;
        vecs[idx].k = k;
        for (int i = 0; i < 4; i++)
            for (int kk = 0; kk < 16; kk++) begin
                vecs[idx].a[i][kk] = av;
                vecs[idx].b[kk][i] = bv;
            end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) vecs[idx].c[i][j] = cv;
    endtask

    task automatic start_and_feed(input int v);
        int n;
        int cyc;
        bit hs;
        k_len    = 5'(vecs[v].k);
        acc_keep = vecs[v].keep;
        start    = 1'b1;
        step();
        start = 1'b0;
        chk($sformatf("v%0d busy_feed", v), busy, 1);
        chk($sformatf("v%0d in_ready_feed", v), in_ready, 1);
        n   = 0;
        cyc = 0;
        while (n < vecs[v].k && cyc < 200) begin
            in_valid = vecs[v].gap ? (cyc % 2 == 0) : 1'b1;
            for (int i = 0; i < 4; i++) begin
                a_data[i*16 +: 16] = vecs[v].a[i][n];
                b_data[i*16 +: 16] = vecs[v].b[n][i];
            end
            if (vecs[v].poke) begin
                start = 1'b1;
                k_len = 5'd1;
            end
            hs = in_valid && in_ready;
            step();
            cyc++;
            if (hs) n++;
        end
        chk($sformatf("v%0d beats_taken", v), 64'(n), 64'(vecs[v].k));
        start    = 1'b0;
        in_valid = 1'b0;
        a_data   = '0;
        b_data   = '0;
    endtask

    task automatic run_job(input int v);
        int          lat;
        logic [63:0] exp_row;
        start_and_feed(v);
        lat = 1;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
        chk($sformatf("v%0d latency", v), 64'(lat), 64'd7);
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) exp_row[j*16 +: 16] = vecs[v].c[r][j];
            chk($sformatf("v%0d out_valid r%0d", v, r), out_valid, 1);
            chk($sformatf("v%0d out_row r%0d", v, r), out_row, 64'(r));
            chk($sformatf("v%0d out_data r%0d", v, r), out_data, exp_row);
            if (vecs[v].stall && r == 1) begin
                out_ready = 1'b0;
                repeat (5) begin
                    step();
                    chk($sformatf("v%0d stall out_row", v), out_row, 64'd1);
                    chk($sformatf("v%0d stall out_data", v), out_data, exp_row);
                end
            end
            out_ready = 1'b1;
            step();
        end
        chk($sformatf("v%0d done_pulse", v), done, 1);
        chk($sformatf("v%0d busy_after", v), busy, 0);
        chk($sformatf("v%0d out_valid_after", v), out_valid, 0);
        step();
        chk($sformatf("v%0d done_cleared", v), done, 0);
    endtask

    initial begin
        bvals = '{'{16'h3C00, 16'h4000, 16'h4200, 16'h4400},
                  '{16'h4000, 16'h4400, 16'h4600, 16'h4800},
                  '{16'h4200, 16'h4600, 16'h4880, 16'h4A00},
                  '{16'h4400, 16'h4800, 16'h4A00, 16'h4C00}};

        // 1.0 x 2.0 over k=3 -> 6.0
        fill_const(0, 3, 16'h3C00, 16'h4000, 16'h4600);
        // identity A times scaled B -> B
        fill_const(1, 4, 16'h0000, 16'h0000, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            for (int kk = 0; kk < 4; kk++) vecs[1].a[i][kk] = (i == kk) ? 16'h3C00 : 16'h0000;
            for (int j = 0; j < 4; j++) begin
                vecs[1].b[i][j] = bvals[i][j];
                vecs[1].c[i][j] = bvals[i][j];
            end
        end
        // bubbles on in_valid
        fill_const(2, 3, 16'h3C00, 16'h4000, 16'h4600);
        vecs[2].gap = 1'b1;
        // minimum length, negative product, consumer stall on row 1: 2.0 x -1.0 -> -2.0
        fill_const(3, 1, 16'h4000, 16'hBC00, 16'hC000);
        vecs[3].stall = 1'b1;
        // maximum length: 16 x (1.0 x 1.0) -> 16.0
        fill_const(4, 16, 16'h3C00, 16'h3C00, 16'h4C00);
        // start held high while busy must not disturb the job
        fill_const(5, 3, 16'h3C00, 16'h4000, 16'h4600);
        vecs[5].poke = 1'b1;
`ifdef PE_ARRAY_ACC_KEEP_EN
        // second job on top of vector 5 without clearing: 6.0 + 6.0 -> 12.0
        fill_const(6, 3, 16'h3C00, 16'h4000, 16'h4A00);
        vecs[6].keep = 1'b1;
`endif

        // reset state
        step();
        step();
        chk("rst in_ready", in_ready, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst out_row", out_row, 0);
        chk("rst out_data", out_data, 0);
        reset = 1'b1;
        step();

        // k_len out of range is ignored
        for (int t = 0; t < 2; t++) begin
            k_len = (t == 0) ? 5'd0 : 5'd17;
            start = 1'b1;
            step();
            start = 1'b0;
            repeat (3) begin
                chk($sformatf("bad_k%0d busy", t), busy, 0);
                chk($sformatf("bad_k%0d out_valid", t), out_valid, 0);
                step();
            end
        end

        // reset in the middle of FLUSH abandons the job
        start_and_feed(0);
        step();
        step();
        chk("flush busy", busy, 1);
        reset = 1'b0;
        #1;
        chk("mid_rst in_ready", in_ready, 0);
        chk("mid_rst out_valid", out_valid, 0);
        chk("mid_rst busy", busy, 0);
        chk("mid_rst done", done, 0);
        chk("mid_rst out_row", out_row, 0);
        chk("mid_rst out_data", out_data, 0);
        step();
        reset = 1'b1;
        repeat (12) begin
            step();
            chk("post_rst out_valid", out_valid, 0);
        end

        for (int v = 0; v < NV; v++) run_job(v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pe_array_nxn.md
PE_ARRAY_NXN -- requirements
Module: pe_array_nxn

Interface
REQ-001 SHALL have parameter ROWS, default 4: PE rows (1..8).
REQ-002 SHALL have parameter COLS, default 4: PE columns (1..8).
REQ-003 SHALL have parameter DATA_WIDTH, default 16: FP16 operand/result width.
REQ-004 SHALL have parameter KMAX, default 16: maximum reduction length.
REQ-005 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-006 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start  input  1  begin a job (sampled in IDLE only).
REQ-008 SHALL have port k_len  input  $clog2(KMAX+1)  reduction length, sampled with start.
REQ-009 SHALL have port in_valid  input  1  operand beat valid.
REQ-010 SHALL have port in_ready  output  1  operand beat accepted when in_valid&in_ready.
REQ-011 SHALL have port a_data  input  ROWS*DATA_WIDTH  A column k, row i at slice i.
REQ-012 SHALL have port b_data  input  COLS*DATA_WIDTH  B row k, column j at slice j.
REQ-013 SHALL have port out_valid  output  1  result row beat valid.
REQ-014 SHALL have port out_ready  input  1  consumer accepts result beat.
REQ-015 SHALL have port out_row  output  $clog2(ROWS)  index of row on out_data.
REQ-016 SHALL have port out_data  output  COLS*DATA_WIDTH  C[out_row][0..COLS-1].
REQ-017 SHALL have ports busy and done  output  1 each  job active; one-cycle completion pulse.

Function
REQ-018 SHALL compute C = A(ROWSxk_len) * B(k_lenxCOLS) with FP16 MAC per PE, accumulators cleared at start.
REQ-019 SHALL skew inputs internally: row i of A delayed i cycles, column j of B delayed j cycles; user presents unskewed beats.
REQ-020 SHALL implement FSM IDLE->FEED->FLUSH->DRAIN->IDLE.
REQ-021 IDLE: in_ready=0, busy=0; start with k_len in 1..KMAX -> FEED; start with k_len=0 or >KMAX ignored.
REQ-022 FEED: in_ready=1; each handshake advances the whole array (skew regs + PEs) one step; in_valid=0 freezes the array; after k_len beats -> FLUSH.
REQ-023 FLUSH: injects zeros for exactly ROWS+COLS-2 cycles (no stall), then -> DRAIN; first out_valid ROWS+COLS-1 cycles after last accepted beat.
REQ-024 DRAIN: out_valid=1, out_row from 0 to ROWS-1, advancing only on out_valid&out_ready; out_data/out_row stable while stalled.
REQ-025 SHALL pulse done for one cycle on the cycle after the final row handshake, returning to IDLE that cycle.
REQ-026 start asserted while busy SHALL be ignored.

Reset
REQ-027 reset low SHALL force IDLE, clear skew regs, accumulators, counters; in_ready, out_valid, busy, done, out_row, out_data all 0.
REQ-028 reset mid-job SHALL abandon the job; no out_valid until a new start completes.

Configuration
REQ-029 Macro PE_ARRAY_ACC_KEEP_EN defined: input acc_keep (1 bit) sampled with start; acc_keep=1 preserves accumulators, so consecutive jobs sum partial products (K-split).
REQ-030 PE_ARRAY_ACC_KEEP_EN undefined: acc_keep port absent; accumulators always cleared at start.

Structure
REQ-031 Shared package pe_array_pkg SHALL hold the FSM state enum, FP16 width constant and FP16 constants (zero, one).
REQ-032 One sub-module pe_mac (ports clk, reset, en, clr, a_in, b_in, a_out, b_out, acc) SHALL be instantiated ROWSxCOLS via generate.

Verification
REQ-033 A all 1.0 (0x3C00), B all 2.0 (0x4000), k_len=3, out_ready=1 -> 4 beats, every element 0x4600 (6.0), done after row 3.
REQ-034 A=identity 4x4, B rows [1,2,3,4]-scaled, k_len=4 -> C equals B exactly, out_row 0,1,2,3 in order.
REQ-035 Same as REQ-033 with in_valid low every other cycle -> identical results, first out_valid 7 cycles after last accepted beat.
REQ-036 out_ready low 5 cycles during row 1 -> out_row/out_data held, no beat lost or repeated.
REQ-037 start with k_len=0 -> busy stays 0, no out_valid; reset low during FLUSH -> all outputs 0, IDLE.
REQ-038 With PE_ARRAY_ACC_KEEP_EN: job1 per REQ-033, job2 same operands acc_keep=1 -> all elements 0x4A00 (12.0).
